// File: rtl/aer_encoder_sliced_stream_if.sv
// aer_encoder_sliced_stream_if: frame load, per-lane AER stream and status bundle (optional AER_ENCODER_EVENT_COUNT_EN count)
interface aer_encoder_sliced_stream_if #(
  parameter int NUM_SLICES = 10,
  parameter int VEC_W = 980,
  parameter int AER_W = 10,
  parameter int ROT_W = 4
);
  localparam int CNT_W = $clog2(VEC_W + 1);
  logic start_i;
  logic [VEC_W-1:0] hot_vector_i;
  logic [ROT_W-1:0] rot_i;
  logic [NUM_SLICES-1:0] ready_i;
  logic [NUM_SLICES*AER_W-1:0] aer_o;
  logic [NUM_SLICES-1:0] valid_o;
  logic valid_any_o;
  logic busy_o;
  logic done_o;
`ifdef AER_ENCODER_EVENT_COUNT_EN
  logic [CNT_W-1:0] event_count_o;
  modport master (output start_i, hot_vector_i, rot_i, ready_i,
                  input aer_o, valid_o, valid_any_o, busy_o, done_o, event_count_o);
  modport slave (input start_i, hot_vector_i, rot_i, ready_i,
                 output aer_o, valid_o, valid_any_o, busy_o, done_o, event_count_o);
`else
  modport master (output start_i, hot_vector_i, rot_i, ready_i,
                  input aer_o, valid_o, valid_any_o, busy_o, done_o);
  modport slave (input start_i, hot_vector_i, rot_i, ready_i,
                 output aer_o, valid_o, valid_any_o, busy_o, done_o);
`endif
endinterface

// File: rtl/aer_encoder_sliced_stream.sv
// aer_encoder_sliced_stream: interleaved-slice AER encoder with rotated valid/ready lanes (optional AER_ENCODER_EVENT_COUNT_EN counter)
module aer_encoder_sliced_stream #(
  parameter int NUM_SLICES = 10,
  parameter int VEC_W = 980,
  parameter int AER_W = 10,
  parameter int ROT_W = 4
) (
  input logic clk,
  input logic reset,
  aer_encoder_sliced_stream_if.slave bus
);
  localparam int SLICE_W = VEC_W / NUM_SLICES;
  localparam int CNT_W = $clog2(VEC_W + 1);
  logic [SLICE_W-1:0] sl_q [NUM_SLICES];
  logic [SLICE_W-1:0] sl_d [NUM_SLICES];
  logic [AER_W-1:0] adr_q [NUM_SLICES];
  logic [AER_W-1:0] adr_d [NUM_SLICES];
  logic [SLICE_W-1:0] lo;
  logic [NUM_SLICES-1:0] vld_q, vld_d, fire;
  logic [ROT_W-1:0] rot_q;
  logic busy_q, busy_d, done_q, done_d;
  int r;
  // The presented event is always the lowest remaining bit, so a fire just clears the lowest set bit
  always_comb begin
    r = (int'(rot_q) >= NUM_SLICES) ? 0 : int'(rot_q);
    lo = '0;
    fire = '0;
    vld_d = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      fire[s] = vld_q[s] & bus.ready_i[(s + r) % NUM_SLICES];
      for (int k = 0; k < SLICE_W; k++) lo[k] = bus.hot_vector_i[k*NUM_SLICES + s];
      sl_d[s] = bus.start_i ? lo : fire[s] ? (sl_q[s] & (sl_q[s] - SLICE_W'(1))) : sl_q[s];
      vld_d[s] = |sl_d[s];
      adr_d[s] = '0;
      for (int k = SLICE_W - 1; k >= 0; k--) if (sl_d[s][k]) adr_d[s] = AER_W'(k*NUM_SLICES + s);
    end
    busy_d = |vld_d;
    done_d = bus.start_i ? ~busy_d : (busy_q & ~busy_d);
  end
  // Output lane m shows slice (m - r) mod NUM_SLICES
  always_comb begin
    bus.aer_o = '0;
    bus.valid_o = '0;
    for (int m = 0; m < NUM_SLICES; m++) begin
      bus.aer_o[m*AER_W +: AER_W] = adr_q[(m - r + NUM_SLICES) % NUM_SLICES];
      bus.valid_o[m] = vld_q[(m - r + NUM_SLICES) % NUM_SLICES];
    end
    bus.valid_any_o = |vld_q;
    bus.busy_o = busy_q;
    bus.done_o = done_q;
  end
  // Slice contents, encoder results, rotation and frame status
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLICES; s++) begin
        sl_q[s] <= '0;
        adr_q[s] <= '0;
      end
      vld_q <= '0;
      rot_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLICES; s++) begin
        sl_q[s] <= sl_d[s];
        adr_q[s] <= adr_d[s];
      end
      vld_q <= vld_d;
      rot_q <= bus.start_i ? bus.rot_i : rot_q;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
`ifdef AER_ENCODER_EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  assign bus.event_count_o = cnt_q;
  // Accepted-event tally for the current frame; a start discards that cycle's fires
  always_ff @(posedge clk) begin
    if (reset || bus.start_i) cnt_q <= '0;
    else cnt_q <= cnt_q + CNT_W'($countones(fire));
  end
`endif
endmodule

// File: tb/tb_aer_encoder_sliced_stream.sv
// tb_aer_encoder_sliced_stream: scoreboarded directed bench for aer_encoder_sliced_stream (event count checked under AER_ENCODER_EVENT_COUNT_EN)
module tb_aer_encoder_sliced_stream;
  localparam int N = 10;
  localparam int VW = 980;
  localparam int AW = 10;
  localparam int RW = 4;
  typedef struct { int lane; int addr; } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ev_t q[$];
  aer_encoder_sliced_stream_if #(.NUM_SLICES(N), .VEC_W(VW), .AER_W(AW), .ROT_W(RW)) bus ();
  aer_encoder_sliced_stream #(.NUM_SLICES(N), .VEC_W(VW), .AER_W(AW), .ROT_W(RW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int lane_aer(input int m);
    logic [N*AW-1:0] a;
    a = bus.aer_o;
    return int'(a[m*AW +: AW]);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int lane, input int addr);
    ev_t e;
    e.lane = lane;
    e.addr = addr;
    q.push_back(e);
  endtask
  task automatic start(input logic [VW-1:0] v, input logic [RW-1:0] r);
    bus.hot_vector_i = v;
    bus.rot_i = r;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask
  task automatic wait_done(input string name, input int exp_n);
    int n = 0;
    while (!bus.done_o && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_cycles"}, n, exp_n);
    chk({name, "_done"}, bus.done_o, 1);
    chk({name, "_busy_low"}, bus.busy_o, 0);
    chk({name, "_valid_low"}, bus.valid_o, 0);
    tick();
    chk({name, "_done_once"}, bus.done_o, 0);
  endtask
  // Scoreboard monitor: every lane handshake pops the next expected event
  always @(negedge clk) begin
    if (!reset && !bus.start_i) begin
      for (int m = 0; m < N; m++) begin
        if (bus.valid_o[m] && bus.ready_i[m]) begin
          if (q.size() == 0) chk($sformatf("unexpected_lane%0d", m), lane_aer(m), 1023);
          else begin
            ev_t e;
            e = q.pop_front();
            chk("fire_lane", m, e.lane);
            chk("fire_aer", lane_aer(m), e.addr);
          end
        end
      end
    end
  end
  initial begin
    logic [VW-1:0] v;
    bus.start_i = 1'b0;
    bus.hot_vector_i = '0;
    bus.rot_i = '0;
    bus.ready_i = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_aer", bus.aer_o, 0);
    v = '0; v[0] = 1'b1; v[13] = 1'b1; v[979] = 1'b1;
    start(v, 0);
    chk("mid_valid", bus.valid_o, 10'b10_0000_1001);
    chk("mid_busy", bus.busy_o, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_done", bus.done_o, 0);
    chk("mid_rst_aer", bus.aer_o, 0);
    tick();
    chk("mid_rst_no_done", bus.done_o, 0);
    bus.ready_i = '1;
    push(3, 3); push(3, 13); push(3, 23);
    v = '0; v[3] = 1'b1; v[13] = 1'b1; v[23] = 1'b1;
    start(v, 0);
    chk("seq_busy", bus.busy_o, 1);
    chk("seq_valid_any", bus.valid_any_o, 1);
    wait_done("seq", 3);
    bus.ready_i = 10'b11_1101_1111;
    push(5, 5); push(5, 15);
    v = '0; v[5] = 1'b1; v[15] = 1'b1;
    start(v, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_aer", lane_aer(5), 5);
      chk("bp_hold_valid", bus.valid_o[5], 1);
      tick();
    end
    bus.ready_i = '1;
    wait_done("bp", 2);
    bus.ready_i = '0;
    push(9, 7);
    v = '0; v[7] = 1'b1;
    start(v, 2);
    chk("rot2_valid", bus.valid_o, 10'b10_0000_0000);
    chk("rot2_aer", lane_aer(9), 7);
    bus.ready_i = '1;
    wait_done("rot2", 1);
    push(7, 7);
    start(v, 12);
    chk("rot12_valid", bus.valid_o, 10'b00_1000_0000);
    wait_done("rot12", 1);
    start('0, 0);
    chk("zero_busy", bus.busy_o, 0);
    chk("zero_done", bus.done_o, 1);
    tick();
    chk("zero_done_once", bus.done_o, 0);
    chk("zero_busy_after", bus.busy_o, 0);
    bus.ready_i = '0;
    v = '0; v[3] = 1'b1; v[13] = 1'b1;
    start(v, 0);
    bus.ready_i = '1;
    push(0, 970);
    v = '0; v[970] = 1'b1;
    start(v, 0);
    chk("abort_valid", bus.valid_o, 10'b00_0000_0001);
    chk("abort_aer", lane_aer(0), 970);
    chk("abort_no_done", bus.done_o, 0);
    wait_done("abort", 1);
    for (int c = 0; c < VW / N; c++)
      for (int m = 0; m < N; m++) push(m, c * N + m);
    start('1, 0);
    wait_done("full", 98);
`ifdef AER_ENCODER_EVENT_COUNT_EN
    chk("event_count", bus.event_count_o, 980);
`endif
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
